gpio_in_cond: RTL



---
 rtl/gpio_in_cond_if.sv | 20 ++
 rtl/gpio_in_cond.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/gpio_in_cond_if.sv
// Register-window bus for gpio_in_cond: a valid/ready request with a
// registered one-cycle acknowledge. The master holds valid until it sees ready.
interface gpio_in_cond_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
    logic [31:0] rdata;
    logic        ready;

    modport master (
        output addr, wdata, wstrb, valid,
        input  rdata, ready
    );

    modport slave (
        input  addr, wdata, wstrb, valid,
        output rdata, ready
    );
endinterface

// File: rtl/gpio_in_cond.sv
// GPIO input conditioning: 2-flop synchronizer, per-bit debounce with a
// programmable hold time, rise/fall edge detection into sticky pending bits,
// and a small register window on the valid/ready bus.
module gpio_in_cond #(
    parameter logic [31:0]      BASE_ADDR  = 32'h1000_0040,
    parameter int               CNT_W      = 16,
    parameter logic [CNT_W-1:0] DB_DEFAULT = CNT_W'(100)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    ui_in,
    output logic [7:0]    ui_clean,
    output logic          irq,
    gpio_in_cond_if.slave bus
);

    logic [7:0]       sync1_q;
    logic [7:0]       sync2_q;
    logic [7:0]       clean_dly_q;
    logic [7:0]       rise_en_q, rise_en_d;
    logic [7:0]       fall_en_q, fall_en_d;
    logic [7:0]       pending_q, pending_d;
    logic [CNT_W-1:0] db_limit_q, db_limit_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             ready_q, ready_d;

    // Counter value at which a held level is accepted; a limit of 0 acts as 1.
    logic [CNT_W-1:0] last_cnt;
    assign last_cnt = (db_limit_q == '0) ? '0 : db_limit_q - CNT_W'(1);

    // Two-stage synchronizer on the raw pads.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= ui_in;
            sync2_q <= sync1_q;
        end
    end

    // One independent debounce counter and clean flop per input bit.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_db
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             clean_q, clean_d;

            // Count consecutive cycles the synchronized bit disagrees with the clean bit.
            always_comb begin
                cnt_d   = cnt_q;
                clean_d = clean_q;
                if (sync2_q[gi] == clean_q) begin
                    cnt_d = '0;
                end else if (cnt_q == last_cnt) begin
                    clean_d = sync2_q[gi];
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Debounce state registers.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q   <= '0;
                    clean_q <= 1'b0;
                end else begin
                    cnt_q   <= cnt_d;
                    clean_q <= clean_d;
                end
            end

            assign ui_clean[gi] = clean_q;
        end
    endgenerate

    logic [31:0] offset;
    logic [31:0] rd_val;
    logic        access;
    logic        is_write;
    logic [7:0]  set_bits;
    logic [7:0]  clr_bits;

    // Bus decode, register read mux, edge detect and next-state for the register file.
    always_comb begin
        offset   = bus.addr - BASE_ADDR;
        access   = bus.valid && !ready_q;
        is_write = access && (bus.wstrb != 4'b0000);

        case (offset)
            32'h00:  rd_val = {16'h0000, sync2_q, ui_clean};
            32'h04:  rd_val = {24'h0, rise_en_q};
            32'h08:  rd_val = {24'h0, fall_en_q};
            32'h0C:  rd_val = {24'h0, pending_q};
            32'h10:  rd_val = 32'(db_limit_q);
            default: rd_val = '0;
        endcase

        set_bits = (ui_clean & ~clean_dly_q & rise_en_q)
                 | (~ui_clean & clean_dly_q & fall_en_q);
        clr_bits = (is_write && offset == 32'h0C && bus.wstrb[0]) ? bus.wdata[7:0] : 8'h00;
        // A new edge beats a same-cycle software clear.
        pending_d = (pending_q & ~clr_bits) | set_bits;

        rise_en_d = rise_en_q;
        if (is_write && offset == 32'h04 && bus.wstrb[0]) rise_en_d = bus.wdata[7:0];

        fall_en_d = fall_en_q;
        if (is_write && offset == 32'h08 && bus.wstrb[0]) fall_en_d = bus.wdata[7:0];

        db_limit_d = db_limit_q;
        if (is_write && offset == 32'h10) begin
            if (bus.wstrb[0]) db_limit_d[7:0]       = bus.wdata[7:0];
            if (bus.wstrb[1]) db_limit_d[CNT_W-1:8] = bus.wdata[CNT_W-1:8];
        end

        rdata_d = rdata_q;
        if (access && !is_write) rdata_d = rd_val;

        ready_d = access;
    end

    // Register file, edge-detect delay and bus response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            clean_dly_q <= '0;
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            pending_q   <= '0;
            db_limit_q  <= DB_DEFAULT;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
        end else begin
            clean_dly_q <= ui_clean;
            rise_en_q   <= rise_en_d;
            fall_en_q   <= fall_en_d;
            pending_q   <= pending_d;
            db_limit_q  <= db_limit_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
        end
    end

    assign irq       = |pending_q;
    assign bus.ready = ready_q;
    assign bus.rdata = rdata_q;

    // Write-data bits above the widest register have no destination.
    logic unused_wdata;
    assign unused_wdata = ^bus.wdata[31:CNT_W];

endmodule
